// File: rtl/bus_arbiter_ctrl.sv
// Two-master round-robin bus arbiter: one memory access in flight at a time,
// with a per-access timeout that completes the access with an error flag.

module bus_arbiter_port (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic        done,
    input  logic        load,
    input  logic [31:0] load_data,
    output logic        ack,
    output logic [31:0] rdata
);
    assign ack = done & sel;

    // Read data only moves for the winning master; everyone else holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rdata <= '0;
        else if (load && sel)
            rdata <= load_data;
    end
endmodule

module bus_arbiter_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int RR_INIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_rw,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ack,
    input  logic        m1_req,
    input  logic        m1_rw,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ack,
    output logic        bus_err,
    output logic        mem_en,
    output logic        mem_rw,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);
    localparam int              NUM_MST = 2;
    localparam int              CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(TIMEOUT - 1);
    localparam logic            RR_LAST = 1'(RR_INIT);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    typedef struct packed {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mreq_t;

    state_t                       state, state_nxt;
    mreq_t  [NUM_MST-1:0]         mreq;
    mreq_t                        lat;
    logic   [NUM_MST-1:0]         req, sel, ack;
    logic   [NUM_MST-1:0][31:0]   rdata;
    logic                         win, win_nxt, last_gnt, err;
    logic                         grant, expire, load, done;
    logic   [CW-1:0]              cnt;
    logic   [31:0]                load_data;

    assign req     = {m1_req, m0_req};
    assign mreq[0] = {m0_rw, m0_addr, m0_wdata};
    assign mreq[1] = {m1_rw, m1_addr, m1_wdata};

    // Contention goes to whichever master was not granted last.
    assign win_nxt = (req == 2'b11) ? ~last_gnt : req[1];

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        expire    = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    grant     = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (mem_ready) begin
                    state_nxt = DONE;
                end else if (cnt == CNT_MAX) begin
                    expire    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            win      <= 1'b0;
            last_gnt <= RR_LAST;
            lat      <= '0;
            cnt      <= '0;
            err      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                win      <= win_nxt;
                last_gnt <= win_nxt;
                lat      <= mreq[win_nxt];
                cnt      <= '0;
                err      <= 1'b0;
            end else if (state == ACCESS && !mem_ready && !expire) begin
                cnt <= cnt + CW'(1);
            end
            if (expire)
                err <= 1'b1;
        end
    end

    // A timed-out access returns zero data whether it was a read or a write.
    assign done      = (state == DONE);
    assign load      = (state == ACCESS) && ((mem_ready && !lat.rw) || expire);
    assign load_data = expire ? 32'h0000_0000 : mem_rdata;

    assign mem_en    = (state == ACCESS);
    assign mem_rw    = lat.rw;
    assign mem_addr  = lat.addr;
    assign mem_wdata = lat.wdata;
    assign bus_err   = done && err;

    genvar g;
    generate
        for (g = 0; g < NUM_MST; g++) begin : g_port
            assign sel[g] = (win == 1'(g));
            bus_arbiter_port u_port (
                .clk       (clk),
                .rst       (rst),
                .sel       (sel[g]),
                .done      (done),
                .load      (load),
                .load_data (load_data),
                .ack       (ack[g]),
                .rdata     (rdata[g])
            );
        end
    endgenerate

    assign m0_ack   = ack[0];
    assign m1_ack   = ack[1];
    assign m0_rdata = rdata[0];
    assign m1_rdata = rdata[1];
endmodule

// File: tb/tb_bus_arbiter_ctrl.sv
// Directed bench for bus_arbiter_ctrl: a transaction-level reference model
// checked every cycle, plus hand-computed expectations at key points.

module tb_bus_arbiter_ctrl;
    localparam int TIMEOUT = 16;
    localparam int RR_INIT = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m0_rw = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0;
    logic [31:0] m0_rdata;
    logic        m0_ack;
    logic        m1_req = 1'b0, m1_rw = 1'b0;
    logic [31:0] m1_addr = '0, m1_wdata = '0;
    logic [31:0] m1_rdata;
    logic        m1_ack;
    logic        bus_err, mem_en, mem_rw;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    bus_arbiter_ctrl #(.TIMEOUT(TIMEOUT), .RR_INIT(RR_INIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_rw     (m0_rw),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_rdata  (m0_rdata),
        .m0_ack    (m0_ack),
        .m1_req    (m1_req),
        .m1_rw     (m1_rw),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_rdata  (m1_rdata),
        .m1_ack    (m1_ack),
        .bus_err   (bus_err),
        .mem_en    (mem_en),
        .mem_rw    (mem_rw),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: at most one open access; once it completes, a single
    // response cycle follows, and only after that can a new grant happen.
    bit          m_open, m_resp, m_err, m_who, m_last, m_rw;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] m_rdata [2];
    int          m_age;

    task automatic model_reset();
        m_open = 0; m_resp = 0; m_err = 0; m_who = 0; m_rw = 0;
        m_last = 1'(RR_INIT);
        m_addr = '0; m_wdata = '0; m_age = 0;
        m_rdata[0] = '0; m_rdata[1] = '0;
    endtask

    task automatic model_step();
        if (m_resp) begin
            m_resp = 0;
        end else if (m_open) begin
            m_age++;
            if (mem_ready === 1'b1 || m_age >= TIMEOUT) begin
                m_err  = (mem_ready !== 1'b1);
                m_open = 0;
                m_resp = 1;
                if (m_err)      m_rdata[m_who] = '0;
                else if (!m_rw) m_rdata[m_who] = mem_rdata;
            end
        end else if (m0_req || m1_req) begin
            if (m0_req && m1_req) m_who = !m_last;
            else                  m_who = m1_req;
            m_last  = m_who;
            m_open  = 1;
            m_age   = 0;
            m_rw    = m_who ? m1_rw    : m0_rw;
            m_addr  = m_who ? m1_addr  : m0_addr;
            m_wdata = m_who ? m1_wdata : m0_wdata;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else      model_step();
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin
            chk("cyc_mem_en",  32'(mem_en),  32'(m_open));
            if (m_open) begin
                chk("cyc_mem_rw",    32'(mem_rw), 32'(m_rw));
                chk("cyc_mem_addr",  mem_addr,    m_addr);
                chk("cyc_mem_wdata", mem_wdata,   m_wdata);
            end
            chk("cyc_m0_ack",   32'(m0_ack),  32'(m_resp && !m_who));
            chk("cyc_m1_ack",   32'(m1_ack),  32'(m_resp &&  m_who));
            chk("cyc_bus_err",  32'(bus_err), 32'(m_resp &&  m_err));
            chk("cyc_m0_rdata", m0_rdata,     m_rdata[0]);
            chk("cyc_m1_rdata", m1_rdata,     m_rdata[1]);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_mem_en(input string name);
        int n;
        n = 0;
        while (mem_en !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        chk(name, 32'(mem_en), 32'd1);
    endtask

    task automatic finish_access(input int waits, input logic [31:0] rd);
        repeat (waits) tick();
        mem_ready = 1'b1;
        mem_rdata = rd;
        tick();
        mem_ready = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
    endtask

    initial begin
        #1 rst = 1'b0;
        #1;
        chk("rst_mem_en",    32'(mem_en),  32'd0);
        chk("rst_mem_rw",    32'(mem_rw),  32'd0);
        chk("rst_mem_addr",  mem_addr,     32'd0);
        chk("rst_mem_wdata", mem_wdata,    32'd0);
        chk("rst_m0_ack",    32'(m0_ack),  32'd0);
        chk("rst_m1_ack",    32'(m1_ack),  32'd0);
        chk("rst_bus_err",   32'(bus_err), 32'd0);
        chk("rst_m0_rdata",  m0_rdata,     32'd0);
        chk("rst_m1_rdata",  m1_rdata,     32'd0);
        tick(); tick();
        rst = 1'b1;
        tick();

        // Stray mem_ready while idle must be ignored
        mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_ready = 1'b0;
        chk("stray_ready_idle", 32'(mem_en), 32'd0);

        // Single read, minimum latency
        m0_req = 1'b1; m0_rw = 1'b0; m0_addr = 32'h0000_0040;
        tick();
        chk("t1_en_latency", 32'(mem_en), 32'd1);
        chk("t1_addr",       mem_addr,    32'h0000_0040);
        mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        mem_ready = 1'b0;
        chk("t1_ack",    32'(m0_ack),  32'd1);
        chk("t1_rdata",  m0_rdata,     32'h1234_5678);
        chk("t1_err",    32'(bus_err), 32'd0);
        chk("t1_m1_ack", 32'(m1_ack),  32'd0);
        m0_req = 1'b0;
        tick();
        chk("t1_ack_one_cycle", 32'(m0_ack), 32'd0);

        // Simultaneous requests alternate, m1 first after reset
        m0_req = 1'b1; m0_addr = 32'h0000_0100;
        m1_req = 1'b1; m1_rw = 1'b0; m1_addr = 32'h0000_0200;
        wait_mem_en("t2a_grant");
        chk("t2a_m1_first", mem_addr, 32'h0000_0200);
        finish_access(0, 32'hA1A1_0001);
        chk("t2a_m1_ack",   32'(m1_ack), 32'd1);
        chk("t2a_m0_noack", 32'(m0_ack), 32'd0);
        chk("t2a_m1_rdata", m1_rdata,    32'hA1A1_0001);
        chk("t2a_m0_hold",  m0_rdata,    32'h1234_5678);
        m1_req = 1'b0;
        wait_mem_en("t2b_grant");
        chk("t2b_m0_second", mem_addr, 32'h0000_0100);
        finish_access(1, 32'hB2B2_0002);
        chk("t2b_m0_ack",   32'(m0_ack), 32'd1);
        chk("t2b_m0_rdata", m0_rdata,    32'hB2B2_0002);
        chk("t2b_m1_hold",  m1_rdata,    32'hA1A1_0001);
        m0_addr = 32'h0000_0104; m1_req = 1'b1; m1_addr = 32'h0000_0204;
        wait_mem_en("t2c_grant");
        chk("t2c_m1_again", mem_addr, 32'h0000_0204);
        finish_access(0, 32'hC3C3_0003);
        chk("t2c_m1_ack", 32'(m1_ack), 32'd1);
        m1_req = 1'b0;
        wait_mem_en("t2d_grant");
        chk("t2d_m0_again", mem_addr, 32'h0000_0104);
        finish_access(0, 32'hD4D4_0004);
        chk("t2d_m0_ack", 32'(m0_ack), 32'd1);
        m0_req = 1'b0;

        // Write with three wait cycles; master inputs wiggle mid-access
        m1_req = 1'b1; m1_rw = 1'b1; m1_addr = 32'h0000_1000; m1_wdata = 32'hCAFE_F00D;
        wait_mem_en("t3_grant");
        for (int i = 0; i < 3; i++) begin
            chk("t3_en",    32'(mem_en), 32'd1);
            chk("t3_rw",    32'(mem_rw), 32'd1);
            chk("t3_addr",  mem_addr,    32'h0000_1000);
            chk("t3_wdata", mem_wdata,   32'hCAFE_F00D);
            if (i == 1) begin
                m1_addr = 32'hFFFF_0000; m1_wdata = 32'h0000_FFFF;
            end
            tick();
        end
        chk("t3_addr_at_ready", mem_addr, 32'h0000_1000);
        mem_ready = 1'b1; mem_rdata = 32'h0BAD_0BAD;
        tick();
        mem_ready = 1'b0;
        chk("t3_m1_ack",        32'(m1_ack),  32'd1);
        chk("t3_err",           32'(bus_err), 32'd0);
        chk("t3_m1_rdata_hold", m1_rdata,     32'hC3C3_0003);
        m1_req = 1'b0; m1_rw = 1'b0;
        tick();
        chk("t3_ack_one_cycle", 32'(m1_ack), 32'd0);

        // Timeout: no mem_ready for TIMEOUT access cycles
        m0_req = 1'b1; m0_rw = 1'b0; m0_addr = 32'h0000_2000;
        wait_mem_en("t4_grant");
        repeat (TIMEOUT - 1) tick();
        chk("t4_still_waiting", 32'(mem_en), 32'd1);
        chk("t4_no_ack_yet",    32'(m0_ack), 32'd0);
        tick();
        chk("t4_ack",        32'(m0_ack),  32'd1);
        chk("t4_bus_err",    32'(bus_err), 32'd1);
        chk("t4_rdata_zero", m0_rdata,     32'd0);
        chk("t4_en_low",     32'(mem_en),  32'd0);
        m0_req = 1'b0;
        tick();
        chk("t4_err_one_cycle", 32'(bus_err), 32'd0);

        // mem_ready on the last allowed cycle is a success
        m0_req = 1'b1; m0_addr = 32'h0000_2004;
        wait_mem_en("t5_grant");
        repeat (TIMEOUT - 1) tick();
        mem_ready = 1'b1; mem_rdata = 32'h5A5A_0016;
        tick();
        mem_ready = 1'b0;
        chk("t5_ack",   32'(m0_ack),  32'd1);
        chk("t5_noerr", 32'(bus_err), 32'd0);
        chk("t5_rdata", m0_rdata,     32'h5A5A_0016);
        m0_req = 1'b0;
        tick();

        // Requester drops req mid-access, ack still comes
        m1_req = 1'b1; m1_rw = 1'b0; m1_addr = 32'h0000_3000;
        wait_mem_en("t6_grant");
        m1_req = 1'b0;
        finish_access(2, 32'h6666_0006);
        chk("t6_ack_after_drop", 32'(m1_ack), 32'd1);
        chk("t6_rdata",          m1_rdata,    32'h6666_0006);
        tick();

        // Reset mid-access
        m1_req = 1'b1; m1_addr = 32'h0000_3100;
        wait_mem_en("t7_grant");
        tick();
        #1 rst = 1'b0;
        #1;
        chk("t7_async_mem_en", 32'(mem_en), 32'd0);
        chk("t7_rst_m1_rdata", m1_rdata,    32'd0);
        chk("t7_rst_m0_rdata", m0_rdata,    32'd0);
        chk("t7_rst_addr",     mem_addr,    32'd0);
        m1_req = 1'b0;
        tick(); tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t7_no_ack", 32'(m1_ack), 32'd0);
            chk("t7_idle",   32'(mem_en), 32'd0);
            tick();
        end
        // Round-robin pointer returns to RR_INIT, so m1 wins again
        m0_req = 1'b1; m0_addr = 32'h0000_0044;
        m1_req = 1'b1; m1_addr = 32'h0000_0048;
        tick();
        chk("t7_new_grant",    32'(mem_en), 32'd1);
        chk("t7_rr_reset_m1",  mem_addr,    32'h0000_0048);
        finish_access(0, 32'h7777_0007);
        chk("t7_m1_ack",   32'(m1_ack), 32'd1);
        chk("t7_m1_rdata", m1_rdata,    32'h7777_0007);
        m1_req = 1'b0;
        wait_mem_en("t7_m0_grant");
        chk("t7_m0_addr", mem_addr, 32'h0000_0044);
        finish_access(0, 32'h8888_0008);
        chk("t7_m0_ack",   32'(m0_ack), 32'd1);
        chk("t7_m0_rdata", m0_rdata,    32'h8888_0008);
        m0_req = 1'b0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bus_arbiter_ctrl.md
BUS_ARBITER_CTRL -- requirements
Module: bus_arbiter_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16: max cycles ACCESS waits for mem_ready before aborting.
REQ-002 Parameter RR_INIT, default 0: master treated as last-granted after reset.
REQ-003 clk  input  1  single system clock, all state on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 m0_req  input  1  master 0 (instruction fetch) request, held until m0_ack.
REQ-006 m0_rw  input  1  master 0 direction, 1=write, 0=read.
REQ-007 m0_addr  input  32  master 0 byte address.
REQ-008 m0_wdata  input  32  master 0 write data.
REQ-009 m0_rdata  output  32  master 0 read data, valid with m0_ack.
REQ-010 m0_ack  output  1  master 0 completion pulse.
REQ-011 m1_req, m1_rw, m1_addr, m1_wdata, m1_rdata, m1_ack  same widths and directions as master 0, for master 1 (data port).
REQ-012 bus_err  output  1  pulse with ack when the access timed out.
REQ-013 mem_en  output  1  memory access strobe.
REQ-014 mem_rw  output  1  memory direction, 1=write.
REQ-015 mem_addr  output  32  memory address.
REQ-016 mem_wdata  output  32  memory write data.
REQ-017 mem_rdata  input  32  memory read data, valid when mem_ready.
REQ-018 mem_ready  input  1  memory completion, one cycle.

Function
REQ-019 FSM states IDLE, ACCESS, DONE; exactly one active.
REQ-020 IDLE: if any req sampled high, latch winner id, rw, addr, wdata; go ACCESS next cycle; else stay.
REQ-021 Arbitration: single requester wins; both high -> the master not last granted wins (round-robin); last-granted updates on every grant.
REQ-022 ACCESS: mem_en=1, mem_rw/mem_addr/mem_wdata driven from latched values, stable for the whole state.
REQ-023 ACCESS with mem_ready=1: capture mem_rdata (reads only), go DONE.
REQ-024 Timeout counter clears on ACCESS entry, increments each ACCESS cycle without mem_ready; at count TIMEOUT-1 without mem_ready, go DONE with error flag set, captured rdata = 32'h0000_0000.
REQ-025 mem_ready arriving in the same cycle as timeout expiry counts as success, no error.
REQ-026 DONE: assert winner's ack for exactly one cycle, rdata on winner's port, bus_err=error flag; return IDLE.
REQ-027 Non-winner ack and bus_err always 0; non-winner rdata holds previous value.
REQ-028 Minimum latency: req at cycle N -> mem_en at N+1 -> mem_ready at N+1 -> ack at N+2; next grant no earlier than N+3.
REQ-029 A requester dropping req before ack does not abort the in-flight access; ack is still issued.
REQ-030 mem_ready outside ACCESS is ignored.
REQ-031 All outputs registered or decoded only from state; no combinational path from req to mem_en.

Reset
REQ-032 rst low forces, asynchronously: state IDLE, mem_en=0, mem_rw=0, mem_addr=0, mem_wdata=0, m0_ack=0, m1_ack=0, m0_rdata=0, m1_rdata=0, bus_err=0, timeout counter=0, last-granted=RR_INIT.
REQ-033 Reset during ACCESS drops mem_en immediately; the in-flight access is abandoned, no ack issued after release.
REQ-034 First grant evaluation occurs on the first rising edge with rst high.

Verification
REQ-035 m0 read addr 0x0000_0040, mem_ready next cycle with rdata 0x1234_5678 -> m0_ack one cycle, m0_rdata=0x1234_5678, bus_err=0, ack two cycles after req.
REQ-036 m0 and m1 request simultaneously after reset (RR_INIT=0) -> m1 served first, then m0; repeat both -> m1 then m0 again, alternating.
REQ-037 m1 write addr 0x0000_1000 data 0xCAFE_F00D -> mem_en, mem_rw=1, mem_addr/mem_wdata stable until mem_ready after 3 wait cycles; m1_ack pulse.
REQ-038 m0 read, mem_ready never asserted -> after 16 ACCESS cycles m0_ack and bus_err pulse together, m0_rdata=0.
REQ-039 mem_ready on the 16th ACCESS cycle -> success, bus_err=0.
REQ-040 rst low mid-ACCESS -> mem_en=0 without a clock edge; after release, no ack for the abandoned access, new requests served normally.
